window_productor: RTL and testbench
===================================

Name: window_productor

Overview:
Streaming sliding-window generator feeding the systolic PE array of the CNN accelerator. It accepts a feature map one word per handshake in raster order and buffers it in KERNEL-1 line buffers plus a KERNEL x KERNEL window register. It emits every KERNEL x KERNEL window as one flattened bus word. Frame width, frame height and stride are run-time configurable, and both the input and output sides carry ready/valid backpressure.

Parameters:
WORDWIDTH, 32, bits per feature-map word
MAX_FIG_WIDTH, 28, largest supported frame width; sets line-buffer depth
KERNEL, 5, window side length
ARRAYLEN, 25, window element count; must equal KERNEL*KERNEL
FIG_ADDRLEN, 5, row/column counter width; 2**FIG_ADDRLEN >= MAX_FIG_WIDTH

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; latches cfg_* and begins a frame
cfg_fig_width  input  FIG_ADDRLEN  frame width W
cfg_fig_height  input  FIG_ADDRLEN  frame height H
cfg_stride  input  2  stride S, legal values 1..3
din  input  WORDWIDTH  pixel, raster order
in_valid  input  1  din valid
in_ready  output  1  block accepts din this cycle
dout  output  WORDWIDTH*ARRAYLEN  flattened window
out_valid  output  1  dout valid
out_ready  input  1  downstream accepts dout
busy  output  1  frame in progress
done  output  1  one-cycle pulse after the last window handshake
cfg_err  output  1  one-cycle pulse when start carries an illegal config

Behaviour:
- Single clock domain (clk). rst_n is sampled only on the rising edge of clk.
- Reset values: in_ready=0, out_valid=0, dout=0, busy=0, done=0, cfg_err=0, counters=0, state=IDLE.
- Line-buffer and window-register contents are don't-care after reset.
- Config legality: KERNEL <= W <= MAX_FIG_WIDTH, KERNEL <= H, 1 <= S <= 3.
- States:
  - IDLE: on start with a legal config, latch cfg_*, clear row/col, go to STREAM, busy=1. On start with an illegal config, pulse cfg_err next cycle and stay in IDLE.
  - STREAM: accept pixels.
  - FLUSH: entered after the last pixel (row=H-1, col=W-1) is accepted. Wait until out_valid is 0 or handshaken, then go to IDLE with busy=0 and done=1 for one cycle.
- start is ignored outside IDLE.
- Handshake rules:
  - in_ready = (state==STREAM) && (!out_valid || out_ready).
  - A pixel is accepted when in_valid && in_ready.
  - An output is accepted when out_valid && out_ready.
  - dout is held stable while out_valid && !out_ready.
- On each accepted pixel at (row, col):
  - Window columns shift left by one.
  - The new rightmost column is {linebuf[KERNEL-2..0] at col, din}, oldest row on top.
  - din is written into the line buffers at col; each buffer row shifts up.
  - col increments and wraps at W-1; on wrap, row increments.
- Emission condition, evaluated on the accepted pixel: row>=KERNEL-1, col>=KERNEL-1, (row-(KERNEL-1))%S==0, (col-(KERNEL-1))%S==0.
  - On emission, out_valid=1 on the next cycle (latency 1 from pixel acceptance).
  - If the output is accepted in the same cycle a new window is produced, out_valid stays 1 with the new dout.
- dout layout: element idx=r*KERNEL+c occupies bits [(idx+1)*WORDWIDTH-1 : idx*WORDWIDTH].
  - r=0 is the oldest (top) row; c=0 is the leftmost column.
  - Words are passed through unmodified; there is no arithmetic.
- Window count per frame: ((W-KERNEL)/S+1)*((H-KERNEL)/S+1), integer division.
  - Trailing rows and columns not reachable at stride S are consumed but never emitted.
- Stale columns left in the window from the previous row are never emitted, because of the col>=KERNEL-1 gate.
- Reset mid-frame: return to reset values next cycle. No partial window is emitted and done does not pulse. A fresh start is required.
- Simultaneous start and rst_n=0: reset wins.

Test Plan:
- W=8, H=8, S=1, din=row*8+col, out_ready=1 -> 16 windows. First window: element0=0, element4=4, element24=36. Last window: element0=27, element24=63. done one cycle after the 16th handshake.
- Same stimulus with S=2 -> 4 windows (output rows 0,2 x output columns 0,2). Second window element0=2. Third window element0=16.
- W=28, H=28, S=1, continuous in_valid -> 576 windows. in_ready never drops. busy high from the cycle after start until done.
- 8x8 frame with out_ready held low for 10 cycles while out_valid=1 -> dout unchanged, in_ready=0 throughout, no window lost or duplicated. Final count is still 16.
- start with W=4 (below KERNEL) or S=0 -> cfg_err pulses once, busy stays 0, in_ready stays 0.
- rst_n low for 1 cycle after 30 pixels of an 8x8 frame -> all outputs return to reset values. A new start then yields exactly 16 correct windows.

Source files
------------

// File: rtl/window_productor_if.sv
// window_productor_if
// Bundles the configuration, pixel-stream, window-stream and status signals of
// window_productor.
//   master : driver side (configuration, pixels in, window consumer)
//   slave  : window_productor side
// Signals:
//   start, cfg_fig_width, cfg_fig_height, cfg_stride : frame configuration
//   din, in_valid, in_ready                          : pixel stream
//   dout, out_valid, out_ready                       : flattened window stream
//   busy, done, cfg_err                              : status
interface window_productor_if #(
    parameter int WORDWIDTH   = 32,
    parameter int ARRAYLEN    = 25,
    parameter int FIG_ADDRLEN = 5
);
    logic                          start;
    logic [FIG_ADDRLEN-1:0]        cfg_fig_width;
    logic [FIG_ADDRLEN-1:0]        cfg_fig_height;
    logic [1:0]                    cfg_stride;
    logic [WORDWIDTH-1:0]          din;
    logic                          in_valid;
    logic                          in_ready;
    logic [WORDWIDTH*ARRAYLEN-1:0] dout;
    logic                          out_valid;
    logic                          out_ready;
    logic                          busy;
    logic                          done;
    logic                          cfg_err;

    modport master (
        output start, cfg_fig_width, cfg_fig_height, cfg_stride,
        output din, in_valid, out_ready,
        input  in_ready, dout, out_valid, busy, done, cfg_err
    );

    modport slave (
        input  start, cfg_fig_width, cfg_fig_height, cfg_stride,
        input  din, in_valid, out_ready,
        output in_ready, dout, out_valid, busy, done, cfg_err
    );
endinterface

// File: rtl/window_productor.sv
// window_productor
// Streaming sliding-window generator. Pixels arrive in raster order, are kept
// in KERNEL-1 line buffers plus a KERNEL x KERNEL window register, and every
// window reachable at the configured stride is emitted as one flattened word.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : window_productor_if.slave (config, pixel stream, window stream,
//           busy/done/cfg_err status)
//
// state  | meaning
// IDLE   | waiting for start; config is latched here
// STREAM | accepting pixels, emitting windows
// FLUSH  | last pixel taken; waiting for the final window to drain
module window_productor #(
    parameter int WORDWIDTH     = 32,
    parameter int MAX_FIG_WIDTH = 28,
    parameter int KERNEL        = 5,
    parameter int ARRAYLEN      = 25,
    parameter int FIG_ADDRLEN   = 5
) (
    input logic          clk,
    input logic          rst_n,
    window_productor_if.slave bus
);
    localparam int DW = WORDWIDTH * ARRAYLEN;
    localparam logic [FIG_ADDRLEN-1:0] K_A    = FIG_ADDRLEN'(KERNEL);
    localparam logic [FIG_ADDRLEN-1:0] KM1_A  = FIG_ADDRLEN'(KERNEL - 1);
    localparam logic [FIG_ADDRLEN-1:0] MAXW_A = FIG_ADDRLEN'(MAX_FIG_WIDTH);
    localparam logic [FIG_ADDRLEN-1:0] ONE_A  = FIG_ADDRLEN'(1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t                 state_q, state_d;
    logic [FIG_ADDRLEN-1:0] row_q, row_d, col_q, col_d;
    logic [FIG_ADDRLEN-1:0] w_q, w_d, h_q, h_d;
    logic [1:0]             s_q, s_d;
    logic                   out_valid_q, out_valid_d;
    logic                   done_q, done_d;
    logic                   cfg_err_q, cfg_err_d;
    logic [DW-1:0]          dout_q, dout_d;

    // linebuf_q[0] holds the most recent row, linebuf_q[KERNEL-2] the oldest.
    logic [WORDWIDTH-1:0]   linebuf_q [KERNEL-1][MAX_FIG_WIDTH];
    logic [WORDWIDTH-1:0]   win_q [KERNEL][KERNEL];
    logic [WORDWIDTH-1:0]   win_d [KERNEL][KERNEL];
    logic [DW-1:0]          win_flat;

    logic                   in_ready_w, pix_acc, out_fire, cfg_ok, emit, last_pix;
    logic [FIG_ADDRLEN-1:0] row_off, col_off;

    assign in_ready_w = (state_q == STREAM) && (!out_valid_q || bus.out_ready);
    assign pix_acc    = bus.in_valid && in_ready_w;
    assign out_fire   = out_valid_q && bus.out_ready;
    assign cfg_ok     = (bus.cfg_fig_width >= K_A) && (bus.cfg_fig_width <= MAXW_A) &&
                        (bus.cfg_fig_height >= K_A) && (bus.cfg_stride != 2'd0);

    assign row_off  = row_q - KM1_A;
    assign col_off  = col_q - KM1_A;
    // The col gate also keeps columns left over from the previous row out of
    // any emitted window: by col=KERNEL-1 they have all been shifted out.
    assign emit     = pix_acc && (row_q >= KM1_A) && (col_q >= KM1_A) &&
                      ((row_off % FIG_ADDRLEN'(s_q)) == '0) &&
                      ((col_off % FIG_ADDRLEN'(s_q)) == '0);
    assign last_pix = (row_q == h_q - ONE_A) && (col_q == w_q - ONE_A);

    // Window as it will look after shifting in the current pixel's column.
    always_comb begin
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
        end
        for (int r = 0; r < KERNEL - 1; r++) begin
            win_d[r][KERNEL-1] = linebuf_q[KERNEL-2-r][col_q];
        end
        win_d[KERNEL-1][KERNEL-1] = bus.din;
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
                win_flat[(r*KERNEL+c)*WORDWIDTH +: WORDWIDTH] = win_d[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pix_acc) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL; c++) begin
                    win_q[r][c] <= win_d[r][c];
                end
            end
            linebuf_q[0][col_q] <= bus.din;
            for (int k = 1; k < KERNEL - 1; k++) begin
                linebuf_q[k][col_q] <= linebuf_q[k-1][col_q];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        w_d         = w_q;
        h_d         = h_q;
        s_d         = s_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;

        // A new window in the same cycle as a handshake keeps out_valid high.
        if (out_fire) out_valid_d = 1'b0;
        if (emit) begin
            out_valid_d = 1'b1;
            dout_d      = win_flat;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (cfg_ok) begin
                        w_d     = bus.cfg_fig_width;
                        h_d     = bus.cfg_fig_height;
                        s_d     = bus.cfg_stride;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = STREAM;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (pix_acc) begin
                    if (col_q == w_q - ONE_A) begin
                        col_d = '0;
                        row_d = row_q + ONE_A;
                    end else begin
                        col_d = col_q + ONE_A;
                    end
                    if (last_pix) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!out_valid_q || bus.out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            w_q         <= '0;
            h_q         <= '0;
            s_q         <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            w_q         <= w_d;
            h_q         <= h_d;
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            dout_q      <= dout_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_window_productor.sv
// Directed testbench for window_productor.
module tb_window_productor;
    localparam int WW = 32;
    localparam int K  = 5;
    localparam int AL = 25;
    localparam int FA = 5;
    localparam int DW = WW * AL;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    window_productor_if #(.WORDWIDTH(WW), .ARRAYLEN(AL), .FIG_ADDRLEN(FA)) bus ();

    window_productor #(
        .WORDWIDTH(WW), .MAX_FIG_WIDTH(28), .KERNEL(K), .ARRAYLEN(AL), .FIG_ADDRLEN(FA)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pixel value at raster index p is base+p, so element (r,c) of output
    // window (oy,ox) is base + (oy*s+r)*w + ox*s + c.
    function automatic logic [DW-1:0] exp_win(input int w, input int s, input int k, input int base);
        logic [DW-1:0] v;
        int nx, oy, ox;
        v  = '0;
        nx = (w - K) / s + 1;
        oy = k / nx;
        ox = k % nx;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                v[(r*K+c)*WW +: WW] = WW'(base + (oy*s + r)*w + ox*s + c);
            end
        end
        return v;
    endfunction

    task automatic do_start(input int w, input int h, input int s);
        @(negedge clk);
        bus.start          = 1'b1;
        bus.cfg_fig_width  = FA'(w);
        bus.cfg_fig_height = FA'(h);
        bus.cfg_stride     = 2'(s);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_frame(input int w, input int h, input int s, input int base,
                             input int stall_win, input int stall_len, input bit flow_chk,
                             output int nwin, output logic [DW-1:0] win0,
                             output logic [DW-1:0] win1, output logic [DW-1:0] win2,
                             output logic [DW-1:0] winl, output int fire_cyc,
                             output int done_cyc);
        int pix = 0;
        int cyc = 0;
        int stall_left = 0;
        bit stall_used = 1'b0;
        bit done_seen = 1'b0;
        int total = w * h;
        logic [DW-1:0] held = '0;
        nwin = 0; win0 = '0; win1 = '0; win2 = '0; winl = '0;
        fire_cyc = -1; done_cyc = -1;
        while (!done_seen && cyc < 4000) begin
            @(negedge clk);
            if (stall_len > 0 && !stall_used && bus.out_valid && nwin == stall_win) begin
                stall_left = stall_len;
                stall_used = 1'b1;
                held       = bus.dout;
            end
            bus.out_ready = (stall_left == 0);
            bus.in_valid  = (pix < total);
            bus.din       = WW'(base + pix);
            #1;
            if (stall_left > 0) begin
                chk("stall_dout_hold", bus.dout, held);
                chk("stall_in_ready", bus.in_ready, 1'b0);
                chk("stall_out_valid", bus.out_valid, 1'b1);
                stall_left--;
            end
            if (flow_chk && pix < total) begin
                chk("flow_in_ready", bus.in_ready, 1'b1);
                chk("flow_busy", bus.busy, 1'b1);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("window", bus.dout, exp_win(w, s, nwin, base));
                if (nwin == 0) win0 = bus.dout;
                if (nwin == 1) win1 = bus.dout;
                if (nwin == 2) win2 = bus.dout;
                winl     = bus.dout;
                fire_cyc = cyc;
                nwin++;
            end
            if (bus.done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                chk("busy_at_done", bus.busy, 1'b0);
            end
            if (bus.in_valid && bus.in_ready) pix++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("done_within_budget", done_seen, 1'b1);
        chk("pixels_consumed", pix, total);
    endtask

    initial begin
        int nwin, fire_cyc, done_cyc, pix, guard;
        logic [DW-1:0] w0, w1, w2, wl, elem;

        bus.start = 1'b0; bus.cfg_fig_width = '0; bus.cfg_fig_height = '0; bus.cfg_stride = '0;
        bus.din = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;

        // Reset, with a legal start offered while reset is asserted.
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_fig_width = 5'd8; bus.cfg_fig_height = 5'd8; bus.cfg_stride = 2'd1;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_dout", bus.dout, {DW{1'b0}});
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_cfg_err", bus.cfg_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_busy", bus.busy, 1'b0);

        // 8x8, stride 1
        do_start(8, 8, 1);
        run_frame(8, 8, 1, 0, -1, 0, 1'b0, nwin, w0, w1, w2, wl, fire_cyc, done_cyc);
        chk("s1_count", nwin, 16);
        elem = w0 >> (0 * WW);  chk("s1_first_e0", elem[WW-1:0], 32'd0);
        elem = w0 >> (4 * WW);  chk("s1_first_e4", elem[WW-1:0], 32'd4);
        elem = w0 >> (24 * WW); chk("s1_first_e24", elem[WW-1:0], 32'd36);
        elem = wl >> (0 * WW);  chk("s1_last_e0", elem[WW-1:0], 32'd27);
        elem = wl >> (24 * WW); chk("s1_last_e24", elem[WW-1:0], 32'd63);
        chk("s1_done_latency", done_cyc, fire_cyc + 1);
        @(negedge clk);
        #1;
        chk("s1_done_pulse_width", bus.done, 1'b0);

        // 8x8, stride 2
        do_start(8, 8, 2);
        run_frame(8, 8, 2, 0, -1, 0, 1'b0, nwin, w0, w1, w2, wl, fire_cyc, done_cyc);
        chk("s2_count", nwin, 4);
        elem = w1 >> (0 * WW); chk("s2_second_e0", elem[WW-1:0], 32'd2);
        elem = w2 >> (0 * WW); chk("s2_third_e0", elem[WW-1:0], 32'd16);

        // 28x28, stride 1, continuous flow
        do_start(28, 28, 1);
        #1;
        chk("big_busy_after_start", bus.busy, 1'b1);
        run_frame(28, 28, 1, 0, -1, 0, 1'b1, nwin, w0, w1, w2, wl, fire_cyc, done_cyc);
        chk("big_count", nwin, 576);

        // 8x8 with a 10-cycle output stall on the fourth window
        do_start(8, 8, 1);
        run_frame(8, 8, 1, 100, 3, 10, 1'b0, nwin, w0, w1, w2, wl, fire_cyc, done_cyc);
        chk("stall_count", nwin, 16);

        // Illegal configurations
        do_start(4, 8, 1);
        #1;
        chk("cfgw_err", bus.cfg_err, 1'b1);
        chk("cfgw_busy", bus.busy, 1'b0);
        chk("cfgw_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        #1;
        chk("cfgw_err_pulse", bus.cfg_err, 1'b0);
        do_start(8, 8, 0);
        #1;
        chk("cfgs_err", bus.cfg_err, 1'b1);
        chk("cfgs_busy", bus.busy, 1'b0);
        chk("cfgs_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        #1;
        chk("cfgs_err_pulse", bus.cfg_err, 1'b0);
        chk("cfgs_busy_after", bus.busy, 1'b0);

        // Reset after 30 pixels, then a fresh frame
        do_start(8, 8, 1);
        pix = 0;
        guard = 0;
        while (pix < 30 && guard < 200) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.din       = WW'(pix);
            #1;
            if (bus.in_ready) pix++;
            guard++;
        end
        chk("mid_pixels_fed", pix, 30);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_in_ready", bus.in_ready, 1'b0);
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_dout", bus.dout, {DW{1'b0}});
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_done", bus.done, 1'b0);
        chk("mid_rst_cfg_err", bus.cfg_err, 1'b0);
        do_start(8, 8, 1);
        run_frame(8, 8, 1, 500, -1, 0, 1'b0, nwin, w0, w1, w2, wl, fire_cyc, done_cyc);
        chk("restart_count", nwin, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
